// File: rtl/instr_fetch_queue.sv
// Fetch front end: owns the PC, issues reads to a 1-cycle instruction memory and queues {pc, instr}.
// Optional feature macro: IFQ_PERF_CNT_EN adds the stall_cnt_o starved-consumer counter.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_instr_o
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int               PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W+1:0] LVL_DEPTH = (PTR_W+2)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [31:0]      r_fetch_pc;
  logic             r_inflight;
  logic [31:0]      r_inflight_pc;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [31:0]      r_mem_pc    [DEPTH];
  logic [31:0]      r_mem_instr [DEPTH];

  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic [PTR_W+1:0] w_level;
  logic [DEPTH-1:0] w_we;
  logic             w_unused_pc_lsb;

  // Occupancy plus the slot reserved by an outstanding read: never lets a response overflow.
  assign w_level = {1'b0, r_count} + {{(PTR_W+1){1'b0}}, r_inflight};
  assign w_issue = rst_n && !redirect_i && (w_level < LVL_DEPTH);
  assign w_pop   = (r_count != '0) && out_ready_i;
  assign w_push  = r_inflight && !redirect_i;

  assign imem_req_o  = w_issue;
  assign imem_addr_o = r_fetch_pc;
  assign out_valid_o = (r_count != '0);
  assign out_pc_o    = r_mem_pc[r_rd_ptr];
  assign out_instr_o = r_mem_instr[r_rd_ptr];

  assign w_unused_pc_lsb = ^redirect_pc_i[1:0];

  // PC and outstanding-request tracking; a redirect kills the response arriving this cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect_i) begin
      r_fetch_pc <= {redirect_pc_i[31:2], 2'b00};
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc    <= r_fetch_pc + 32'd4;
        r_inflight_pc <= r_fetch_pc;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n || redirect_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
    assign w_we[gi] = w_push && (r_wr_ptr == PTR_W'(gi));
  end

  // Storage is cleared on reset so the head reads as zero before the first fetch lands.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]    <= '0;
        r_mem_instr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_we[i]) begin
          r_mem_pc[i]    <= r_inflight_pc;
          r_mem_instr[i] <= imem_rdata_i;
        end
      end
    end
  end

`ifdef IFQ_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (out_ready_i && !out_valid_o && !redirect_i && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

  property p_no_overflow;
    @(posedge clk_i) disable iff (!rst_n) (w_push && !w_pop) |-> (r_count < (PTR_W+1)'(DEPTH));
  endproperty
  a_no_overflow: assert property (p_no_overflow);

endmodule
